// File: rtl/haze_window_generator_3x3_if.sv
// Pixel-in / window-out stream bundle for the 3x3 haze window generator.
// The master drives pixels and consumes windows; the slave is the generator.
interface haze_window_generator_3x3_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pixel;
  logic        out_valid;
  logic [23:0] window_pixel_1;
  logic [23:0] window_pixel_2;
  logic [23:0] window_pixel_3;
  logic [23:0] window_pixel_4;
  logic [23:0] window_pixel_5;
  logic [23:0] window_pixel_6;
  logic [23:0] window_pixel_7;
  logic [23:0] window_pixel_8;
  logic [23:0] window_pixel_9;
  logic        frame_done;

  modport master (
    output in_valid, in_pixel,
    input  in_ready, out_valid, frame_done,
    input  window_pixel_1, window_pixel_2, window_pixel_3,
    input  window_pixel_4, window_pixel_5, window_pixel_6,
    input  window_pixel_7, window_pixel_8, window_pixel_9
  );

  modport slave (
    input  in_valid, in_pixel,
    output in_ready, out_valid, frame_done,
    output window_pixel_1, window_pixel_2, window_pixel_3,
    output window_pixel_4, window_pixel_5, window_pixel_6,
    output window_pixel_7, window_pixel_8, window_pixel_9
  );
endinterface

// File: rtl/haze_window_generator_3x3.sv
// Raster-order 3x3 RGB window generator with two line buffers, edge replication
// and an internal flush of the trailing W+1 centres after the last input pixel.
module haze_window_generator_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  haze_window_generator_3x3_if.slave   s_bus
);
  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_flush_last;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_frame_done;
  logic [71:0] r_c1;
  logic [71:0] r_c2;
  logic [23:0] r_win [9];
  logic [23:0] r_lb1 [IMG_WIDTH];
  logic [23:0] r_lb2 [IMG_WIDTH];

  logic        w_flush;
  logic        w_step;
  logic        w_emit;
  logic [23:0] w_top;
  logic [23:0] w_mid;
  logic [23:0] w_bot;
  logic [71:0] w_v;
  logic [71:0] w_left;
  logic [71:0] w_cent;
  logic [71:0] w_right;
  logic [23:0] w_win [9];
  logic [CW-1:0] w_col_next;
  logic [RW-1:0] w_row_next;

  // Column triple {top,mid,bottom} for the current column with vertical clamping,
  // and window assembly from the two stored triples plus the new one.
  always_comb begin
    w_flush    = (r_state == S_FLUSH);
    w_step     = w_flush | (s_bus.in_valid & r_in_ready);
    w_emit     = w_step & (r_state != S_FILL);
    w_col_next = (r_col == COL_LAST) ? COL_ZERO : (r_col + COL_ONE);
    w_row_next = (r_col != COL_LAST) ? r_row :
                 ((r_row == ROW_LAST) ? ROW_ZERO : (r_row + ROW_ONE));
    w_mid      = r_lb1[r_col];
    w_top      = (!w_flush && (r_row == ROW_ONE)) ? w_mid : r_lb2[r_col];
    w_bot      = w_flush ? w_mid : s_bus.in_pixel;
    w_v        = {w_top, w_mid, w_bot};
    // Column 0 finishes the previous row's last centre: right edge replicates.
    if (r_col == COL_ZERO) begin
      w_left  = r_c2;
      w_cent  = r_c1;
      w_right = r_c1;
    end else if (r_col == COL_ONE) begin
      w_left  = r_c1;
      w_cent  = r_c1;
      w_right = w_v;
    end else begin
      w_left  = r_c2;
      w_cent  = r_c1;
      w_right = w_v;
    end
    w_win[0] = w_left[71:48];
    w_win[1] = w_cent[71:48];
    w_win[2] = w_right[71:48];
    w_win[3] = w_left[47:24];
    w_win[4] = w_cent[47:24];
    w_win[5] = w_right[47:24];
    w_win[6] = w_left[23:0];
    w_win[7] = w_cent[23:0];
    w_win[8] = w_right[23:0];
  end

  // Line buffers shift one row down on every real accept; never reset.
  always_ff @(posedge clk) begin
    if (w_step && !w_flush && !rst) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= s_bus.in_pixel;
    end
  end

  // Control FSM, column shift registers and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FILL;
      r_flush_last <= 1'b0;
      r_col        <= COL_ZERO;
      r_row        <= ROW_ZERO;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_c1         <= 72'h0;
      r_c2         <= 72'h0;
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= 24'h0;
      end
    end else begin
      r_out_valid  <= w_emit;
      r_frame_done <= 1'b0;
      if (w_emit) begin
        for (int i = 0; i < 9; i++) begin
          r_win[i] <= w_win[i];
        end
      end
      if (w_step) begin
        r_c2 <= r_c1;
        r_c1 <= w_v;
      end
      case (r_state)
        S_FILL: begin
          if (w_step) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
            if ((r_row == ROW_ONE) && (r_col == COL_ZERO)) begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_step) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
            if ((r_row == ROW_LAST) && (r_col == COL_LAST)) begin
              r_state    <= S_FLUSH;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          // W virtual bottom-row steps, then one more for the final centre.
          if (r_flush_last) begin
            r_state      <= S_FILL;
            r_flush_last <= 1'b0;
            r_in_ready   <= 1'b1;
            r_frame_done <= 1'b1;
          end else begin
            r_col <= w_col_next;
            if (r_col == COL_LAST) begin
              r_flush_last <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_FILL;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_bus.in_ready       = r_in_ready;
  assign s_bus.out_valid      = r_out_valid;
  assign s_bus.frame_done     = r_frame_done;
  assign s_bus.window_pixel_1 = r_win[0];
  assign s_bus.window_pixel_2 = r_win[1];
  assign s_bus.window_pixel_3 = r_win[2];
  assign s_bus.window_pixel_4 = r_win[3];
  assign s_bus.window_pixel_5 = r_win[4];
  assign s_bus.window_pixel_6 = r_win[5];
  assign s_bus.window_pixel_7 = r_win[6];
  assign s_bus.window_pixel_8 = r_win[7];
  assign s_bus.window_pixel_9 = r_win[8];
endmodule

// File: tb/tb_haze_window_generator_3x3.sv
// Directed bench for a 4x4 haze_window_generator_3x3: clamp model scoreboard,
// flush timing, back-to-back frames, input gaps and mid-frame reset.
module tb_haze_window_generator_3x3;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  haze_window_generator_3x3_if bus ();
  haze_window_generator_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int scen = 0;
  int win_cnt = 0;
  int fd_cnt = 0;
  logic [23:0] img [N];

  logic        m_rst;
  logic        m_acc;
  int          m_idx;
  int          acc_cnt;
  int          since;
  logic [215:0] obs_win;

  assign obs_win = {bus.window_pixel_1, bus.window_pixel_2, bus.window_pixel_3,
                    bus.window_pixel_4, bus.window_pixel_5, bus.window_pixel_6,
                    bus.window_pixel_7, bus.window_pixel_8, bus.window_pixel_9};

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [215:0] ref_win(input int k);
    logic [215:0] w;
    int r, c, rr, cc;
    r = k / W;
    c = k % W;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        w = {w[191:0], img[rr * W + cc]};
      end
    end
    return w;
  endfunction

  // Accept tracking: index of the last accept and cycles since the last pixel of a frame.
  always @(posedge clk) begin
    m_rst <= rst;
    if (rst) begin
      m_acc   <= 1'b0;
      m_idx   <= 0;
      acc_cnt <= 0;
      since   <= 99;
    end else begin
      m_acc <= bus.in_valid && bus.in_ready;
      m_idx <= acc_cnt;
      if (bus.in_valid && bus.in_ready) acc_cnt <= (acc_cnt == N - 1) ? 0 : acc_cnt + 1;
      if (bus.in_valid && bus.in_ready && acc_cnt == N - 1) since <= 0;
      else if (since < 99) since <= since + 1;
    end
  end

  // Output checks half a cycle after every active edge.
  always @(negedge clk) begin
    bit ev;
    bit fl;
    int ek;
    if (m_rst) begin
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_frame_done", bus.frame_done, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_window", obs_win, 216'h0);
    end else begin
      fl = (since >= 1) && (since <= W + 1);
      ev = (m_acc && (m_idx >= W + 1)) || fl;
      ek = fl ? (N - W - 2 + since) : (m_idx - (W + 1));
      chk("in_ready", bus.in_ready, (since > W) ? 1'b1 : 1'b0);
      chk("out_valid", bus.out_valid, ev);
      chk("frame_done", bus.frame_done, (ev && ek == N - 1) ? 1'b1 : 1'b0);
      if (ev && bus.out_valid) begin
        win_cnt++;
        if (bus.frame_done) fd_cnt++;
        chk("window", obs_win, ref_win(ek));
        if (scen == 1 || scen == 3) begin
          if (ek == 0)
            chk("win_c0", obs_win, {24'd0, 24'd0, 24'd1, 24'd0, 24'd0, 24'd1, 24'd4, 24'd4, 24'd5});
          if (ek == 5)
            chk("win_c5", obs_win, {24'd0, 24'd1, 24'd2, 24'd4, 24'd5, 24'd6, 24'd8, 24'd9, 24'd10});
          if (ek == 15)
            chk("win_c15", obs_win, {24'd10, 24'd11, 24'd11, 24'd14, 24'd15, 24'd15, 24'd14, 24'd15, 24'd15});
        end
      end
    end
  end

  task automatic wait_ready();
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", bus.in_ready, 1'b1);
  endtask

  task automatic drive_frame(input int n, input int max_gap, input bit hold);
    for (int j = 0; j < n; j++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_pixel = img[j];
      wait_ready();
      @(negedge clk);
    end
    bus.in_valid = hold;
    bus.in_pixel = 24'hBADBAD;
    if (n == N) wait_ready();
    else bus.in_valid = 1'b0;
  endtask

  task automatic finish_scen(input string tag, input int w0, input int f0,
                             input int nwin, input int nfd);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_windows"}, win_cnt - w0, nwin);
    chk({tag, "_frame_dones"}, fd_cnt - f0, nfd);
  endtask

  initial begin
    int w0, f0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pixel = 24'h0;
    for (int i = 0; i < N; i++) img[i] = 24'(i);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Continuous index image, two back-to-back frames.
    scen = 1;
    w0 = win_cnt; f0 = fd_cnt;
    drive_frame(N, 0, 1'b1);
    drive_frame(N, 0, 1'b0);
    finish_scen("s1", w0, f0, 2 * N, 2);

    // Per-channel distinct pixels, random gaps, in_valid held during flush.
    scen = 2;
    for (int i = 0; i < N; i++) img[i] = {8'(i * 17), 8'(8'd255 - 8'(i)), 8'(i * 3 + 64)};
    w0 = win_cnt; f0 = fd_cnt;
    drive_frame(N, 2, 1'b1);
    drive_frame(N, 2, 1'b1);
    finish_scen("s2", w0, f0, 2 * N, 2);

    // Reset after a partial frame, then a full frame with gaps.
    scen = 3;
    for (int i = 0; i < N; i++) img[i] = 24'(i);
    w0 = win_cnt; f0 = fd_cnt;
    drive_frame(7, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_frame(N, 1, 1'b0);
    finish_scen("s3", w0, f0, 2 + N, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
